// File: rtl/pdm_audio_pkg.sv
// Shared encodings and constants for the PDM microphone sequencer.
package pdm_audio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_STARTING = 3'd1,
    ST_SETTLING = 3'd2,
    ST_RUNNING  = 3'd3,
    ST_STOPPING = 3'd4
  } state_e;

  // HF cycles per PDM clock period
  localparam int PDM_DIV = 4;

  // Raw-line phases at which each channel is stable (clock-low / clock-high half,
  // just before the following edge), before input synchroniser delay.
  localparam int LEFT_PH_BASE  = 1;
  localparam int RIGHT_PH_BASE = 3;

  // Phase at which a channel is seen on the synchronised data line
  function automatic logic [1:0] cap_phase(input int base, input int lat);
    cap_phase = 2'((base + lat) % PDM_DIV);
  endfunction

endpackage

// File: rtl/pdm_audio_ctrl_if.sv
// CPU control/status and bit-pair stream of the PDM sequencer.
interface pdm_audio_ctrl_if #(
  parameter int SETTLE_W = 16
);
  logic                i_start;
  logic                i_stop;
  logic [SETTLE_W-1:0] i_settle_periods;
  logic                o_busy;
  logic                o_running;
  logic                o_bit_valid;
  logic                o_bit_left;
  logic                o_bit_right;

  modport master (
    output i_start, i_stop, i_settle_periods,
    input  o_busy, o_running, o_bit_valid, o_bit_left, o_bit_right
  );

  modport slave (
    input  i_start, i_stop, i_settle_periods,
    output o_busy, o_running, o_bit_valid, o_bit_left, o_bit_right
  );
endinterface

// File: rtl/pdm_audio_capture.sv
// Phase-indexed left/right capture of the synchronised PDM line and pair strobe.
module pdm_audio_capture #(
  parameter int DATA_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] phase,
  input  logic       run,
  input  logic       pdm_data,
  output logic       bit_valid,
  output logic       bit_left,
  output logic       bit_right
);
  import pdm_audio_pkg::*;

  localparam logic [1:0] LEFT_PH  = cap_phase(LEFT_PH_BASE, DATA_LAT);
  localparam logic [1:0] RIGHT_PH = cap_phase(RIGHT_PH_BASE, DATA_LAT);

  logic left_hold_q, left_hold_d;
  logic armed_q, armed_d;
  logic valid_q, valid_d;
  logic out_l_q, out_l_d;
  logic out_r_q, out_r_d;

  // Capture registers; a pair is only emitted when its left half was taken while running
  always_ff @(posedge clk) begin
    if (rst) begin
      left_hold_q <= 1'b0;
      armed_q     <= 1'b0;
      valid_q     <= 1'b0;
      out_l_q     <= 1'b0;
      out_r_q     <= 1'b0;
    end else begin
      left_hold_q <= left_hold_d;
      armed_q     <= armed_d;
      valid_q     <= valid_d;
      out_l_q     <= out_l_d;
      out_r_q     <= out_r_d;
    end
  end

  // Next capture state from phase and run gate
  always_comb begin
    left_hold_d = left_hold_q;
    armed_d     = armed_q;
    valid_d     = 1'b0;
    out_l_d     = out_l_q;
    out_r_d     = out_r_q;
    if (!run) begin
      armed_d = 1'b0;
    end else if (phase == LEFT_PH) begin
      left_hold_d = pdm_data;
      armed_d     = 1'b1;
    end else if (phase == RIGHT_PH && armed_q) begin
      out_l_d = left_hold_q;
      out_r_d = pdm_data;
      valid_d = 1'b1;
      armed_d = 1'b0;
    end
  end

  assign bit_valid = valid_q;
  assign bit_left  = out_l_q;
  assign bit_right = out_r_q;

endmodule

// File: rtl/pdm_audio_ctrl.sv
// PDM microphone sequencer: owns the clock-block enable, mirrors its divider
// phase, discards the settle window and hands bit pairs to the decimator.
module pdm_audio_ctrl #(
  parameter int SYNC_LAT = 2,
  parameter int DATA_LAT = 2,
  parameter int SETTLE_W = 16
) (
  input  logic             i_hf_clock,
  input  logic             i_reset,
  input  logic             i_pdm_data,
  output logic             o_clk_enable,
  pdm_audio_ctrl_if.slave  ctrl
);
  import pdm_audio_pkg::*;

  localparam logic [2:0] START_WAIT = 3'(SYNC_LAT);
  localparam logic [2:0] STOP_WAIT  = 3'(SYNC_LAT + 1);

  state_e              state_q, state_d;
  logic [2:0]          wait_q, wait_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [1:0]          phase_q, phase_d;
  logic                pending_q, pending_d;
  logic                clk_en_q, clk_en_d;

  logic start_req, stop_req, go, wait_done, wrap, run_gate;

  assign start_req = ctrl.i_start & ~ctrl.i_stop;
  assign stop_req  = ctrl.i_stop;
  assign go        = pending_q | start_req;
  assign wait_done = (wait_q <= 3'd1);
  assign wrap      = (phase_q == 2'd3);

  // State and datapath registers
  always_ff @(posedge i_hf_clock) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      wait_q    <= 3'd0;
      settle_q  <= '0;
      phase_q   <= 2'd0;
      pending_q <= 1'b0;
      clk_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      settle_q  <= settle_d;
      phase_q   <= phase_d;
      pending_q <= pending_d;
      clk_en_q  <= clk_en_d;
    end
  end

  // Next-state logic; stop takes priority over everything except in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (go) state_d = ST_STARTING;
      ST_STARTING: begin
        if (stop_req)       state_d = ST_STOPPING;
        else if (wait_done) state_d = (settle_q == '0) ? ST_RUNNING : ST_SETTLING;
      end
      ST_SETTLING: begin
        if (stop_req)                                  state_d = ST_STOPPING;
        else if (wrap && settle_q <= SETTLE_W'(1))     state_d = ST_RUNNING;
      end
      ST_RUNNING:  if (stop_req) state_d = ST_STOPPING;
      ST_STOPPING: if (wait_done) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Counters, phase tracker, pending restart and registered clock enable
  always_comb begin
    wait_d    = wait_q;
    settle_d  = settle_q;
    phase_d   = phase_q + 2'd1;
    pending_d = pending_q;
    case (state_q)
      ST_IDLE: begin
        phase_d = 2'd0;
        if (go) begin
          wait_d    = START_WAIT;
          settle_d  = ctrl.i_settle_periods;
          pending_d = 1'b0;
        end
      end
      ST_STARTING: begin
        // divider still in reset; phase 0 is its first count after release
        phase_d = 2'd0;
        if (wait_q != 3'd0) wait_d = wait_q - 3'd1;
      end
      ST_SETTLING: begin
        if (wrap && settle_q != '0) settle_d = settle_q - SETTLE_W'(1);
      end
      ST_STOPPING: begin
        if (wait_q != 3'd0) wait_d = wait_q - 3'd1;
        if (stop_req)       pending_d = 1'b0;
        else if (start_req) pending_d = 1'b1;
      end
      default: ;
    endcase
    if (state_q != ST_STOPPING && state_d == ST_STOPPING) wait_d = STOP_WAIT;
    if (state_d == ST_IDLE) phase_d = 2'd0;
    clk_en_d = (state_d == ST_STARTING) || (state_d == ST_SETTLING) ||
               (state_d == ST_RUNNING);
  end

  // Status outputs decoded from the current state
  always_comb begin
    ctrl.o_busy    = (state_q != ST_IDLE);
    ctrl.o_running = (state_q == ST_RUNNING);
    o_clk_enable   = clk_en_q;
  end

  // A stop request closes the gate at once so no pair escapes into STOPPING
  assign run_gate = (state_q == ST_RUNNING) && !stop_req;

  pdm_audio_capture #(.DATA_LAT(DATA_LAT)) u_capture (
    .clk       (i_hf_clock),
    .rst       (i_reset),
    .phase     (phase_q),
    .run       (run_gate),
    .pdm_data  (i_pdm_data),
    .bit_valid (ctrl.o_bit_valid),
    .bit_left  (ctrl.o_bit_left),
    .bit_right (ctrl.o_bit_right)
  );

endmodule

// File: tb/tb_pdm_audio_ctrl.sv
// Directed bench: clock-block/mic model around the sequencer, vector table plus corner sequences.
module tb_pdm_audio_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pdm_data;
  logic clk_en, clk_en_b;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pdm_audio_ctrl_if #(.SETTLE_W(16)) cif();
  pdm_audio_ctrl_if #(.SETTLE_W(8))  cifb();

  pdm_audio_ctrl #(.SYNC_LAT(2), .DATA_LAT(2), .SETTLE_W(16)) dut (
    .i_hf_clock(clk), .i_reset(rst), .i_pdm_data(pdm_data),
    .o_clk_enable(clk_en), .ctrl(cif)
  );

  // narrow instance for the all-ones settle boundary
  pdm_audio_ctrl #(.SYNC_LAT(2), .DATA_LAT(2), .SETTLE_W(8)) dut_b (
    .i_hf_clock(clk), .i_reset(rst), .i_pdm_data(pdm_data),
    .o_clk_enable(clk_en_b), .ctrl(cifb)
  );

  // Clock block (2-flop enable sync, divide-by-4) and stereo mic model.
  // Mid-half samples carry the complement so a mistimed capture is visible.
  logic       s1 = 1'b0, s2 = 1'b0, d1 = 1'b0, d2 = 1'b0;
  logic [1:0] cnt = 2'd0;
  logic       mic_l = 1'b0, mic_r = 1'b0;
  logic       raw;
  always_comb begin
    case (cnt)
      2'd0:    raw = ~mic_l;
      2'd1:    raw = mic_l;
      2'd2:    raw = ~mic_r;
      default: raw = mic_r;
    endcase
  end
  always @(posedge clk) begin
    s1  <= clk_en;
    s2  <= s1;
    cnt <= s2 ? cnt + 2'd1 : 2'd0;
    d1  <= raw;
    d2  <= d1;
  end
  assign pdm_data = d2;

  typedef struct {
    logic [15:0] settle;
    logic        l;
    logic        r;
    int          run_cyc;
    int          first_vld;
  } vec_t;
  localparam int NV = 5;
  vec_t vt [NV];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at t=%0t", nm, act, exp, $time);
    end
  endtask

  // start request in cycle 0; returns in cycle 1
  task automatic start_run(input logic [15:0] s);
    cif.i_settle_periods = s;
    cif.i_start = 1'b1;
    step();
    cif.i_start = 1'b0;
  endtask

  task automatic stop_drain();
    cif.i_stop = 1'b1;
    step();
    cif.i_stop = 1'b0;
    repeat (5) step();
  endtask

  task automatic run_vec(input vec_t v);
    logic exp_v;
    mic_l = v.l;
    mic_r = v.r;
    start_run(v.settle);
    for (int c = 1; c <= v.first_vld + 15; c++) begin
      exp_v = (c >= v.first_vld) && ((c - v.first_vld) % 4 == 0);
      chk("clk_en", clk_en, 1'b1);
      chk("busy", cif.o_busy, 1'b1);
      chk("running", cif.o_running, c >= v.run_cyc);
      chk("valid", cif.o_bit_valid, exp_v);
      if (exp_v) begin
        chk("left", cif.o_bit_left, v.l);
        chk("right", cif.o_bit_right, v.r);
      end
      // stop on the right-capture cycle: the pending pair must be dropped
      if (c == v.first_vld + 15) cif.i_stop = 1'b1;
      step();
    end
    cif.i_stop = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk("stop_clk_en", clk_en, 1'b0);
      chk("stop_busy", cif.o_busy, k < 4);
      chk("stop_valid", cif.o_bit_valid, 1'b0);
      step();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic seen;
    vt[0] = '{16'd0, 1'b1, 1'b0, 3, 9};
    vt[1] = '{16'd1, 1'b0, 1'b1, 7, 13};
    vt[2] = '{16'd3, 1'b1, 1'b0, 15, 21};
    vt[3] = '{16'd5, 1'b1, 1'b1, 23, 29};
    vt[4] = '{16'd2, 1'b0, 1'b0, 11, 17};

    cif.i_start = 1'b0;  cif.i_stop = 1'b0;  cif.i_settle_periods = '0;
    cifb.i_start = 1'b0; cifb.i_stop = 1'b0; cifb.i_settle_periods = '0;

    rst = 1'b1;
    repeat (3) step();
    chk("rst_clk_en", clk_en, 1'b0);
    chk("rst_busy", cif.o_busy, 1'b0);
    chk("rst_running", cif.o_running, 1'b0);
    chk("rst_valid", cif.o_bit_valid, 1'b0);
    chk("rst_left", cif.o_bit_left, 1'b0);
    chk("rst_right", cif.o_bit_right, 1'b0);
    rst = 1'b0;
    step();

    for (int i = 0; i < NV; i++) run_vec(vt[i]);

    // start+stop together in IDLE is ignored
    cif.i_start = 1'b1; cif.i_stop = 1'b1;
    step();
    cif.i_start = 1'b0; cif.i_stop = 1'b0;
    chk("idle_both_busy", cif.o_busy, 1'b0);
    chk("idle_both_clk_en", clk_en, 1'b0);
    step();

    // restart requested during STOPPING
    mic_l = 1'b0; mic_r = 1'b1;
    start_run(16'd0);
    repeat (9) step();                       // cycle 10
    cif.i_stop = 1'b1;
    step();                                  // cycle 11, STOPPING
    cif.i_stop = 1'b0;
    cif.i_start = 1'b1;
    step();                                  // cycle 12
    cif.i_start = 1'b0;
    chk("pend_busy12", cif.o_busy, 1'b1);
    step();
    chk("pend_busy13", cif.o_busy, 1'b1);
    step();                                  // cycle 14, IDLE
    chk("pend_idle_busy", cif.o_busy, 1'b0);
    chk("pend_idle_clk_en", clk_en, 1'b0);
    step();                                  // cycle 15, STARTING
    chk("pend_restart_busy", cif.o_busy, 1'b1);
    chk("pend_restart_clk_en", clk_en, 1'b1);
    chk("pend_restart_running", cif.o_running, 1'b0);
    step(); step();                          // cycle 17
    chk("pend_running", cif.o_running, 1'b1);
    repeat (5) step();                       // cycle 22
    chk("pend_no_early_valid", cif.o_bit_valid, 1'b0);
    step();                                  // cycle 23
    chk("pend_valid", cif.o_bit_valid, 1'b1);
    chk("pend_left", cif.o_bit_left, 1'b0);
    chk("pend_right", cif.o_bit_right, 1'b1);
    stop_drain();

    // start+stop together in RUNNING: stop wins, no restart
    start_run(16'd0);
    repeat (9) step();                       // cycle 10
    cif.i_start = 1'b1; cif.i_stop = 1'b1;
    step();                                  // cycle 11
    cif.i_start = 1'b0; cif.i_stop = 1'b0;
    chk("both_clk_en", clk_en, 1'b0);
    chk("both_busy", cif.o_busy, 1'b1);
    repeat (3) step();                       // cycle 14
    chk("both_idle14", cif.o_busy, 1'b0);
    step();
    chk("both_idle15", cif.o_busy, 1'b0);
    step();
    chk("both_idle16", cif.o_busy, 1'b0);
    chk("both_clk_en16", clk_en, 1'b0);

    // reset held 3 cycles mid-RUNNING
    mic_l = 1'b1; mic_r = 1'b0;
    start_run(16'd0);
    repeat (11) step();                      // cycle 12
    chk("pre_reset_running", cif.o_running, 1'b1);
    rst = 1'b1;
    step();                                  // cycle 13
    chk("mreset_clk_en", clk_en, 1'b0);
    chk("mreset_busy", cif.o_busy, 1'b0);
    chk("mreset_running", cif.o_running, 1'b0);
    chk("mreset_valid", cif.o_bit_valid, 1'b0);
    step(); step();
    rst = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      step();
      if (cif.o_bit_valid || cif.o_busy) seen = 1'b1;
    end
    chk("mreset_quiet", seen, 1'b0);

    // all-ones settle count on the 8-bit instance: 255 periods, no wrap
    cifb.i_settle_periods = 8'hFF;
    cifb.i_start = 1'b1;
    step();                                  // cycle 1
    cifb.i_start = 1'b0;
    repeat (1021) step();                    // cycle 1022
    chk("max_settle_busy", cifb.o_busy, 1'b1);
    chk("max_settle_not_run", cifb.o_running, 1'b0);
    step();                                  // cycle 1023
    chk("max_settle_run", cifb.o_running, 1'b1);
    cifb.i_stop = 1'b1;
    step();
    cifb.i_stop = 1'b0;
    repeat (5) step();
    chk("max_settle_idle", cifb.o_busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
